rr_queue: RTL
=============

RR_QUEUE -- requirements
Module: rr_queue

Interface
REQ-001 SIZE, default 10, depth in words of each channel FIFO (>=2).
REQ-002 WIDTH, default 32, data word width in bits (>=1).
REQ-003 CHANNELS, default 4, number of independent input channels (2..16).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  CHANNELS  per-channel write strobe.
REQ-007 data_in  input  CHANNELS x WIDTH  per-channel write data.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data/out_ch hold a valid word.
REQ-010 out_data  output  WIDTH  registered output word.
REQ-011 out_ch  output  clog2(CHANNELS)  source channel of out_data.
REQ-012 empty  output  CHANNELS  per-channel FIFO empty (registered count == 0).
REQ-013 full  output  CHANNELS  per-channel FIFO full (registered count == SIZE).
REQ-014 count  output  CHANNELS x clog2(SIZE+1)  per-channel occupancy.

Function
REQ-015 Each channel SHALL be a circular FIFO; wr_en with !full stores data_in at the write pointer; pointers wrap from SIZE-1 to 0.
REQ-016 A write to a full channel SHALL be dropped, including when the same channel is popped that cycle (full is evaluated on the registered count).
REQ-017 A single output register SHALL be loaded when it is empty, or when out_valid && out_ready, and at least one channel is non-empty.
REQ-018 The load SHALL pop one word from the granted channel, set out_ch to that channel, and hold out_valid high.
REQ-019 The grant SHALL be the first non-empty channel strictly after last_grant, searching cyclically; last_grant updates only on a load.
REQ-020 out_data/out_ch SHALL remain stable while out_valid && !out_ready.
REQ-021 out_valid SHALL fall after a transfer with no non-empty channel.
REQ-022 Latency: a write at edge k into an otherwise idle block SHALL give out_valid high after edge k+1; there is no same-cycle bypass.
REQ-023 Simultaneous write and pop on one non-full channel SHALL leave its count unchanged.
REQ-024 Sustained throughput SHALL be one word per cycle while out_ready=1 and any channel is non-empty.

Reset
REQ-025 While reset=0: pointers and counts 0, empty all 1, full all 0, out_valid 0, out_data 0, out_ch 0, last_grant CHANNELS-1 (channel 0 wins first).
REQ-026 Reset mid-operation SHALL discard all stored and output words immediately; data RAM contents need not be cleared.

Configuration
REQ-027 With RR_QUEUE_ERR_FLAGS_EN defined: extra outputs ovf[CHANNELS] (sticky, set on a dropped write) and busy_cycles (16-bit saturating count of cycles with out_valid && !out_ready); both clear only on reset.
REQ-028 Without RR_QUEUE_ERR_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package rr_queue_pkg SHALL hold the default parameter constants and a function computing the next round-robin grant.
REQ-030 A sub-module rr_queue_chan (one FIFO channel: storage, pointers, count, empty/full) SHALL be instantiated CHANNELS times via generate.

Verification
REQ-031 Reset, then write 0xA0 to ch2 at edge 1, out_ready=1 -> out_valid=1, out_data=0xA0, out_ch=2 after edge 2.
REQ-032 Load ch0..ch3 with 2 words each, out_ready=1 -> output order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3 over 8 consecutive cycles.
REQ-033 Write 11 words to ch1 (SIZE=10) with out_ready=0 -> full[1]=1 after 10 writes, count[1]=10, 11th dropped (ovf[1]=1 when enabled).
REQ-034 Hold out_ready=0 for 5 cycles with valid output -> out_data/out_ch unchanged; busy_cycles=5 when enabled.
REQ-035 Write and pop ch0 on the same cycle at count=3 -> count[0] stays 3; pointer wrap verified over 25 words.
REQ-036 Assert reset mid-stream with 6 words queued -> out_valid=0, all counts 0 on the same cycle; first post-reset grant is ch0.

Source files
------------

// File: rtl/rr_queue_pkg.sv
// rr_queue_pkg -- shared constants and round-robin helper for rr_queue.
//   DEF_SIZE / DEF_WIDTH / DEF_CHANNELS : default parameter values
//   MAX_CHANNELS                        : widest channel vector the helper handles
//   rr_next_grant()                     : first requesting channel strictly after
//                                         'last', searching cyclically over nch
package rr_queue_pkg;

    localparam int DEF_SIZE     = 10;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;
    localparam int MAX_CHANNELS = 16;

    // If nothing requests, 'last' is returned unchanged; callers only use the
    // result when at least one request bit is set.
    function automatic logic [3:0] rr_next_grant(
        input logic [MAX_CHANNELS-1:0] req,
        input logic [3:0]              last,
        input int                      nch
    );
        logic [3:0] g;
        logic       found;
        logic [4:0] idx;
        g     = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CHANNELS; i++) begin
            // last < nch and i <= nch, so one subtraction is enough to wrap
            idx = 5'(last) + 5'(i);
            if (idx >= 5'(nch)) idx = idx - 5'(nch);
            if (i <= nch && !found && req[idx[3:0]]) begin
                g     = idx[3:0];
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_queue_chan.sv
// rr_queue_chan -- one circular FIFO channel of rr_queue.
//   clk, reset          : clock, async active-low reset
//   wr_en_i, wr_data_i  : write strobe / data (dropped when full)
//   pop_i               : remove head word (ignored when empty)
//   head_o              : word at the read pointer
//   empty_o, full_o     : derived from the registered count
//   count_o             : occupancy
module rr_queue_chan
    import rr_queue_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(SIZE+1)-1:0]  count_o
);

    localparam int PW   = $clog2(SIZE);
    localparam int CNTW = $clog2(SIZE+1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem_q [SIZE];
    logic             wr_acc, do_pop;

    // Full is taken from the registered count, so a write to a full channel
    // is dropped even if the same channel is popped this cycle.
    assign full_o  = (count_q == CNTW'(SIZE));
    assign empty_o = (count_q == '0);
    assign wr_acc  = wr_en_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(SIZE-1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = (rd_ptr_q == PW'(SIZE-1)) ? '0 : rd_ptr_q + 1'b1;
        if (wr_acc && !do_pop)      count_d = count_q + 1'b1;
        else if (!wr_acc && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/rr_queue.sv
// rr_queue -- CHANNELS independent FIFOs drained round-robin into a single
// registered output stage with valid/ready handshake.
//   clk, reset            : clock, async active-low reset
//   wr_en, data_in        : per-channel write strobe / data
//   out_ready             : downstream accepts the output word
//   out_valid/out_data/out_ch : registered output word and its source channel
//   empty, full, count    : per-channel status
// Optional (define RR_QUEUE_ERR_FLAGS_EN):
//   ovf         : sticky per-channel dropped-write flag
//   busy_cycles : 16-bit saturating count of out_valid && !out_ready cycles
module rr_queue
    import rr_queue_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [CHANNELS-1:0]                      wr_en,
    input  logic [CHANNELS-1:0][WIDTH-1:0]           data_in,
    input  logic                                     out_ready,
    output logic                                     out_valid,
    output logic [WIDTH-1:0]                         out_data,
    output logic [$clog2(CHANNELS)-1:0]              out_ch,
    output logic [CHANNELS-1:0]                      empty,
    output logic [CHANNELS-1:0]                      full,
    output logic [CHANNELS-1:0][$clog2(SIZE+1)-1:0]  count
`ifdef RR_QUEUE_ERR_FLAGS_EN
   ,output logic [CHANNELS-1:0]                      ovf,
    output logic [15:0]                              busy_cycles
`endif
);

    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] head;
    logic [CHANNELS-1:0]            pop;
    logic                           load;
    logic [CW-1:0]                  grant;
    logic [CW-1:0]                  last_grant_q, last_grant_d;
    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               out_data_q, out_data_d;
    logic [CW-1:0]                  out_ch_q, out_ch_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        rr_queue_chan #(.SIZE(SIZE), .WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (data_in[g]),
            .pop_i     (pop[g]),
            .head_o    (head[g]),
            .empty_o   (empty[g]),
            .full_o    (full[g]),
            .count_o   (count[g])
        );
    end

    assign grant = CW'(rr_next_grant(MAX_CHANNELS'(~empty), 4'(last_grant_q), CHANNELS));

    // Refill when the output stage is empty or is being emptied this cycle.
    assign load = (!out_valid_q || out_ready) && (|(~empty));

    always_comb begin
        pop = '0;
        if (load) pop[grant] = 1'b1;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_data_d   = head[grant];
            out_ch_d     = grant;
            last_grant_d = grant;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            last_grant_q <= CW'(CHANNELS-1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef RR_QUEUE_ERR_FLAGS_EN
    logic [CHANNELS-1:0] ovf_q;
    logic [15:0]         busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q  <= '0;
            busy_q <= '0;
        end else begin
            ovf_q <= ovf_q | (wr_en & full);
            if (out_valid_q && !out_ready && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
        end
    end

    assign ovf         = ovf_q;
    assign busy_cycles = busy_q;
`endif

endmodule
